bcd_step_counter: RTL and testbench

BCD_STEP_COUNTER -- requirements
Module: bcd_step_counter

---
 rtl/bcd_step_counter.sv | 84 ++++++++
 tb/tb_bcd_step_counter.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_step_counter.sv
// Prescaled single-digit BCD up/down counter with synchronous load.
// The digit bits ina..ind are register outputs and feed the downstream code converter directly.
`timescale 1ns/1ps
module bcd_step_counter #(
  parameter int unsigned DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] ld_val,
  output logic       ina,
  output logic       inb,
  output logic       inc,
  output logic       ind,
  output logic       tc,
  output logic       load_err
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [3:0]    digit;
  logic [3:0]    digit_nxt;
  logic [PW-1:0] pre_cnt;
  logic [PW-1:0] pre_nxt;
  logic          tc_nxt;
  logic          err_nxt;
  logic          tick;

  always_comb begin
    tick      = en && (pre_cnt == PRE_MAX);
    digit_nxt = digit;
    pre_nxt   = pre_cnt;
    tc_nxt    = 1'b0;
    err_nxt   = 1'b0;
    // A load of either kind takes the whole cycle, so an illegal value also swallows the tick.
    if (load) begin
      if (ld_val <= 4'd9) begin
        digit_nxt = ld_val;
        pre_nxt   = '0;
      end else begin
        err_nxt = 1'b1;
      end
    end else if (en) begin
      pre_nxt = tick ? '0 : pre_cnt + PW'(1);
      if (tick) begin
        if (up) begin
          if (digit == 4'd9) begin
            digit_nxt = 4'd0;
            tc_nxt    = 1'b1;
          end else begin
            digit_nxt = digit + 4'd1;
          end
        end else begin
          if (digit == 4'd0) begin
            digit_nxt = 4'd9;
            tc_nxt    = 1'b1;
          end else begin
            digit_nxt = digit - 4'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit    <= '0;
      pre_cnt  <= '0;
      tc       <= 1'b0;
      load_err <= 1'b0;
    end else begin
      digit    <= digit_nxt;
      pre_cnt  <= pre_nxt;
      tc       <= tc_nxt;
      load_err <= err_nxt;
    end
  end

  assign {ina, inb, inc, ind} = digit;

endmodule

// File: tb/tb_bcd_step_counter.sv
// Directed bench for bcd_step_counter: DIV=4 main instance plus a DIV=1 instance on shared inputs.
`timescale 1ns/1ps
module tb_bcd_step_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic [3:0] ld_val;
  logic       ina, inb, inc, ind, tc, load_err;
  logic       ina1, inb1, inc1, ind1, tc1, load_err1;
  logic [3:0] dig;
  logic [3:0] dig1;

  int tests;
  int fails;

  bcd_step_counter #(.DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .ld_val(ld_val),
    .ina(ina), .inb(inb), .inc(inc), .ind(ind), .tc(tc), .load_err(load_err)
  );

  bcd_step_counter #(.DIV(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .up(up), .load(load), .ld_val(ld_val),
    .ina(ina1), .inb(inb1), .inc(inc1), .ind(ind1), .tc(tc1), .load_err(load_err1)
  );

  assign dig  = {ina, inb, inc, ind};
  assign dig1 = {ina1, inb1, inc1, ind1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic clk_edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; up = 1'b1; load = 1'b0; ld_val = 4'd0;
    clk_edges(1);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; up = 1'b1; load = 1'b1; ld_val = 4'd5;
    #1;
    tests++;
    if (dig !== 4'd0 || tc !== 1'b0 || load_err !== 1'b0) begin
      fails++;
      $display("FAIL reset_initial: got dig=%0d tc=%b err=%b, exp 0 0 0", dig, tc, load_err);
    end
    clk_edges(2);
    tests++;
    if (dig !== 4'd0 || dig1 !== 4'd0) begin
      fails++;
      $display("FAIL reset_held: got dig=%0d dig1=%0d, exp 0 0", dig, dig1);
    end
    load = 1'b0; en = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 41; k++) begin
      clk_edges(1);
      tests++;
      if (dig !== 4'((k / 4) % 10)) begin
        fails++;
        $display("FAIL count_up_digit k=%0d: got %0d exp %0d", k, dig, (k / 4) % 10);
      end
      tests++;
      if (tc !== (k == 40)) begin
        fails++;
        $display("FAIL count_up_tc k=%0d: got %b exp %b", k, tc, (k == 40));
      end
    end
  endtask

  task automatic test_load_down();
    logic [3:0] exp;
    load = 1'b1; ld_val = 4'd0; up = 1'b0; en = 1'b1;
    clk_edges(1);
    load = 1'b0;
    tests++;
    if (dig !== 4'd0 || tc !== 1'b0) begin
      fails++;
      $display("FAIL load_down_init: got dig=%0d tc=%b exp 0 0", dig, tc);
    end
    for (int k = 1; k <= 12; k++) begin
      clk_edges(1);
      exp = (k < 4) ? 4'd0 : 4'(10 - k / 4);
      tests++;
      if (dig !== exp || tc !== (k == 4)) begin
        fails++;
        $display("FAIL load_down k=%0d: got dig=%0d tc=%b exp dig=%0d tc=%b", k, dig, tc, exp, (k == 4));
      end
    end
  endtask

  task automatic test_illegal_load();
    up = 1'b1; en = 1'b0; load = 1'b1; ld_val = 4'd5;
    clk_edges(1);
    load = 1'b0; en = 1'b1;
    clk_edges(2);
    load = 1'b1; ld_val = 4'd12;
    clk_edges(1);
    load = 1'b0;
    tests++;
    if (dig !== 4'd5 || load_err !== 1'b1 || tc !== 1'b0) begin
      fails++;
      $display("FAIL illegal_load: got dig=%0d err=%b tc=%b exp 5 1 0", dig, load_err, tc);
    end
    clk_edges(1);
    tests++;
    if (dig !== 4'd5 || load_err !== 1'b0) begin
      fails++;
      $display("FAIL illegal_load_hold_pre: got dig=%0d err=%b exp 5 0", dig, load_err);
    end
    clk_edges(1);
    tests++;
    if (dig !== 4'd6) begin
      fails++;
      $display("FAIL illegal_load_next_tick: got %0d exp 6", dig);
    end
    clk_edges(3);
    load = 1'b1; ld_val = 4'd15;
    clk_edges(1);
    load = 1'b0;
    tests++;
    if (dig !== 4'd6 || load_err !== 1'b1) begin
      fails++;
      $display("FAIL illegal_load_tick_suppressed: got dig=%0d err=%b exp 6 1", dig, load_err);
    end
    clk_edges(1);
    tests++;
    if (dig !== 4'd7 || load_err !== 1'b0) begin
      fails++;
      $display("FAIL illegal_load_deferred_tick: got dig=%0d err=%b exp 7 0", dig, load_err);
    end
  endtask

  task automatic test_load_priority();
    up = 1'b1; en = 1'b1; load = 1'b1; ld_val = 4'd9;
    clk_edges(1);
    load = 1'b0;
    clk_edges(3);
    load = 1'b1; ld_val = 4'd3;
    clk_edges(1);
    load = 1'b0;
    tests++;
    if (dig !== 4'd3 || tc !== 1'b0 || load_err !== 1'b0) begin
      fails++;
      $display("FAIL load_priority: got dig=%0d tc=%b err=%b exp 3 0 0", dig, tc, load_err);
    end
    clk_edges(3);
    tests++;
    if (dig !== 4'd3) begin
      fails++;
      $display("FAIL load_priority_restart: got %0d exp 3", dig);
    end
    clk_edges(1);
    tests++;
    if (dig !== 4'd4) begin
      fails++;
      $display("FAIL load_priority_step: got %0d exp 4", dig);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] vals [3];
    vals[0] = 4'd2; vals[1] = 4'd8; vals[2] = 4'd5;
    en = 1'b0; load = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ld_val = vals[i];
      clk_edges(1);
      tests++;
      if (dig !== vals[i]) begin
        fails++;
        $display("FAIL back_to_back[%0d]: got %0d exp %0d", i, dig, vals[i]);
      end
    end
    load = 1'b0;
  endtask

  task automatic test_en_toggle();
    logic [3:0] exp;
    up = 1'b1; en = 1'b0; load = 1'b1; ld_val = 4'd0;
    clk_edges(1);
    load = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      en = (k % 2 == 1);
      clk_edges(1);
      exp = 4'(((k + 1) / 2) / 4);
      tests++;
      if (dig !== exp || tc !== 1'b0) begin
        fails++;
        $display("FAIL en_toggle k=%0d: got dig=%0d tc=%b exp dig=%0d tc=0", k, dig, tc, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    up = 1'b1; en = 1'b0; load = 1'b1; ld_val = 4'd7;
    clk_edges(1);
    load = 1'b0; en = 1'b1;
    clk_edges(2);
    en = 1'b0;
    tests++;
    if (dig !== 4'd7) begin
      fails++;
      $display("FAIL async_reset_setup: got %0d exp 7", dig);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (dig !== 4'd0 || tc !== 1'b0 || load_err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_immediate: got dig=%0d tc=%b err=%b exp 0 0 0", dig, tc, load_err);
    end
    #2 rst_n = 1'b1;
    en = 1'b1;
    clk_edges(3);
    tests++;
    if (dig !== 4'd0) begin
      fails++;
      $display("FAIL async_reset_prescale_cleared: got %0d exp 0", dig);
    end
    clk_edges(1);
    tests++;
    if (dig !== 4'd1) begin
      fails++;
      $display("FAIL async_reset_first_tick: got %0d exp 1", dig);
    end

    load = 1'b1; ld_val = 4'd9;
    clk_edges(1);
    load = 1'b0;
    clk_edges(4);
    tests++;
    if (tc !== 1'b1 || dig !== 4'd0) begin
      fails++;
      $display("FAIL async_reset_tc_setup: got tc=%b dig=%0d exp 1 0", tc, dig);
    end
    en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (tc !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_tc_clear: got %b exp 0", tc);
    end
    #1 rst_n = 1'b1;
    clk_edges(1);
    tests++;
    if (tc !== 1'b0 || dig !== 4'd0) begin
      fails++;
      $display("FAIL async_reset_tc_residual: got tc=%b dig=%0d exp 0 0", tc, dig);
    end

    load = 1'b1; ld_val = 4'd12;
    clk_edges(1);
    load = 1'b0;
    tests++;
    if (load_err !== 1'b1) begin
      fails++;
      $display("FAIL async_reset_err_setup: got %b exp 1", load_err);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (load_err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_err_clear: got %b exp 0", load_err);
    end
    #1 rst_n = 1'b1;
    clk_edges(1);
    tests++;
    if (load_err !== 1'b0) begin
      fails++;
      $display("FAIL async_reset_err_residual: got %b exp 0", load_err);
    end
  endtask

  task automatic test_div1();
    do_reset();
    en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      clk_edges(1);
      tests++;
      if (dig1 !== 4'(k % 10) || tc1 !== (k == 10)) begin
        fails++;
        $display("FAIL div1_up k=%0d: got dig=%0d tc=%b exp dig=%0d tc=%b", k, dig1, tc1, k % 10, (k == 10));
      end
    end
    en = 1'b0;
    clk_edges(2);
    tests++;
    if (dig1 !== 4'd2 || tc1 !== 1'b0) begin
      fails++;
      $display("FAIL div1_hold: got dig=%0d tc=%b exp 2 0", dig1, tc1);
    end
    en = 1'b1; up = 1'b0;
    clk_edges(2);
    tests++;
    if (dig1 !== 4'd0 || tc1 !== 1'b0) begin
      fails++;
      $display("FAIL div1_down: got dig=%0d tc=%b exp 0 0", dig1, tc1);
    end
    clk_edges(1);
    tests++;
    if (dig1 !== 4'd9 || tc1 !== 1'b1) begin
      fails++;
      $display("FAIL div1_down_wrap: got dig=%0d tc=%b exp 9 1", dig1, tc1);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_count_up();
    test_load_down();
    test_illegal_load();
    test_load_priority();
    test_back_to_back();
    test_en_toggle();
    test_async_reset();
    test_div1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
